// File: rtl/h_bdy_be_issue.sv
// Issue stage: pops the body front-end opcode/key/value/hash queues, reassembles
// each command and hands it to the table engine. Define H_BDY_BE_ISSUE_STATS_EN for counters.
module h_bdy_be_issue #(
  parameter int OPCODE_W = 3,
  parameter int K_W      = 32,
  parameter int V_W      = 32,
  parameter int H_W      = 16
`ifdef H_BDY_BE_ISSUE_STATS_EN
  ,
  parameter int STAT_W   = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_op_empty,
  input  logic [OPCODE_W-1:0] i_op_dat,
  output logic                o_op_pop,
  input  logic                i_k_empty,
  input  logic [K_W-1:0]      i_k_dat,
  output logic                o_k_pop,
  input  logic                i_v_empty,
  input  logic [V_W-1:0]      i_v_dat,
  output logic                o_v_pop,
  input  logic                i_h_empty,
  input  logic [H_W-1:0]      i_h_dat,
  output logic                o_h_pop,
  output logic                o_cmd_vld,
  output logic [OPCODE_W-1:0] o_cmd_opcode,
  output logic [K_W-1:0]      o_cmd_k,
  output logic [V_W-1:0]      o_cmd_v,
  output logic [H_W-1:0]      o_cmd_h,
  input  logic                i_cmd_rdy,
  output logic                o_credit,
`ifdef H_BDY_BE_ISSUE_STATS_EN
  output logic [STAT_W-1:0]   o_stat_issued,
  output logic [STAT_W-1:0]   o_stat_stall,
  output logic [STAT_W-1:0]   o_stat_illegal,
`endif
  output logic                o_err_illegal
);

  localparam logic [OPCODE_W-1:0] OP_INSERT = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_DELETE = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_QUERY  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_CLEAR  = OPCODE_W'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0] state, state_nxt;
  logic       need_k, need_v, need_h, illegal, fields_ok;
  logic       hs, eval, fire, ill_pop;

  always_comb begin
    need_k    = (i_op_dat == OP_INSERT) || (i_op_dat == OP_DELETE) || (i_op_dat == OP_QUERY);
    need_v    = (i_op_dat == OP_INSERT);
    need_h    = need_k;
    illegal   = (i_op_dat > OP_CLEAR);
    fields_ok = (!need_k || !i_k_empty) && (!need_v || !i_v_empty) && (!need_h || !i_h_empty);
  end

  // The head is only looked at when no command is held, or the held one leaves this cycle.
  // An illegal head behind a handshake waits a cycle so the credit stays a single pulse.
  assign hs      = (state == S_ISSUE) && i_cmd_rdy && !rst;
  assign eval    = !rst && !i_op_empty && ((state != S_ISSUE) || hs);
  assign fire    = eval && !illegal && fields_ok;
  assign ill_pop = eval && illegal && (state != S_ISSUE);

  assign o_op_pop      = fire || ill_pop;
  assign o_k_pop       = fire && need_k;
  assign o_v_pop       = fire && need_v;
  assign o_h_pop       = fire && need_h;
  assign o_credit      = hs || ill_pop;
  assign o_err_illegal = ill_pop;

  always_comb begin
    state_nxt = state;
    if (fire)                          state_nxt = S_ISSUE;
    else if ((state == S_ISSUE) && !hs) state_nxt = S_ISSUE;
    else if (i_op_empty || illegal)    state_nxt = S_IDLE;
    else                               state_nxt = S_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      o_cmd_vld    <= 1'b0;
      o_cmd_opcode <= '0;
      o_cmd_k      <= '0;
      o_cmd_v      <= '0;
      o_cmd_h      <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        o_cmd_vld    <= 1'b1;
        o_cmd_opcode <= i_op_dat;
        o_cmd_k      <= need_k ? i_k_dat : '0;
        o_cmd_v      <= need_v ? i_v_dat : '0;
        o_cmd_h      <= need_h ? i_h_dat : '0;
      end else if (hs) begin
        o_cmd_vld    <= 1'b0;
        o_cmd_opcode <= '0;
        o_cmd_k      <= '0;
        o_cmd_v      <= '0;
        o_cmd_h      <= '0;
      end
    end
  end

`ifdef H_BDY_BE_ISSUE_STATS_EN
  logic stall;
  assign stall = ((state == S_ISSUE) && !i_cmd_rdy) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_issued  <= '0;
      o_stat_stall   <= '0;
      o_stat_illegal <= '0;
    end else begin
      if (hs && !(&o_stat_issued))       o_stat_issued  <= o_stat_issued + STAT_W'(1);
      if (stall && !(&o_stat_stall))     o_stat_stall   <= o_stat_stall + STAT_W'(1);
      if (ill_pop && !(&o_stat_illegal)) o_stat_illegal <= o_stat_illegal + STAT_W'(1);
    end
  end
`endif

  a_op_pop: assert property (@(posedge clk) disable iff (rst) !(o_op_pop && i_op_empty));
  a_k_pop:  assert property (@(posedge clk) disable iff (rst) !(o_k_pop && i_k_empty));
  a_v_pop:  assert property (@(posedge clk) disable iff (rst) !(o_v_pop && i_v_empty));
  a_h_pop:  assert property (@(posedge clk) disable iff (rst) !(o_h_pop && i_h_empty));

endmodule

// File: tb/tb_h_bdy_be_issue.sv
// Bench for h_bdy_be_issue: queue-level model of the four show-ahead queues and
// the expected command stream, directed scenarios then randomized traffic.
module tb_h_bdy_be_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_op_empty, i_k_empty, i_v_empty, i_h_empty, i_cmd_rdy;
  logic [2:0]  i_op_dat;
  logic [31:0] i_k_dat, i_v_dat;
  logic [15:0] i_h_dat;
  logic        o_op_pop, o_k_pop, o_v_pop, o_h_pop, o_cmd_vld, o_credit, o_err_illegal;
  logic [2:0]  o_cmd_opcode;
  logic [31:0] o_cmd_k, o_cmd_v;
  logic [15:0] o_cmd_h;

  always #5 clk = ~clk;

  h_bdy_be_issue dut (
    .clk(clk), .rst(rst),
    .i_op_empty(i_op_empty), .i_op_dat(i_op_dat), .o_op_pop(o_op_pop),
    .i_k_empty(i_k_empty), .i_k_dat(i_k_dat), .o_k_pop(o_k_pop),
    .i_v_empty(i_v_empty), .i_v_dat(i_v_dat), .o_v_pop(o_v_pop),
    .i_h_empty(i_h_empty), .i_h_dat(i_h_dat), .o_h_pop(o_h_pop),
    .o_cmd_vld(o_cmd_vld), .o_cmd_opcode(o_cmd_opcode), .o_cmd_k(o_cmd_k),
    .o_cmd_v(o_cmd_v), .o_cmd_h(o_cmd_h), .i_cmd_rdy(i_cmd_rdy),
    .o_credit(o_credit), .o_err_illegal(o_err_illegal)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] k;
    logic [31:0] v;
    logic [15:0] h;
  } cmd_t;

  cmd_t        expq[$];
  logic [2:0]  opq[$], opp[$];
  logic [31:0] kq[$], kp[$], vq[$], vp[$];
  logic [15:0] hq[$], hp[$];

  int n_cmp = 0, n_bad = 0;
  int outstanding = 0;
  int cnt_credit = 0, cnt_vld = 0, cnt_vpop = 0;
  bit mon_en = 0, rnd = 0, gen = 0;
  int dprob = 60;
  bit p_op, p_k, p_v, p_h;

  function automatic bit nk(logic [2:0] o); return o inside {3'd1, 3'd2, 3'd3}; endfunction
  function automatic bit nv(logic [2:0] o); return o == 3'd1; endfunction
  function automatic bit legal(logic [2:0] o); return o <= 3'd4; endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    i_op_empty = (opq.size() == 0); i_op_dat = opq.size() ? opq[0] : 3'd0;
    i_k_empty  = (kq.size() == 0);  i_k_dat  = kq.size()  ? kq[0]  : 32'd0;
    i_v_empty  = (vq.size() == 0);  i_v_dat  = vq.size()  ? vq[0]  : 32'd0;
    i_h_empty  = (hq.size() == 0);  i_h_dat  = hq.size()  ? hq[0]  : 16'd0;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [31:0] k, input logic [31:0] v,
                          input logic [15:0] h, input bit with_h);
    cmd_t c;
    opq.push_back(op);
    if (nk(op)) kq.push_back(k);
    if (nv(op)) vq.push_back(v);
    if (nk(op) && with_h) hq.push_back(h);
    c.op = op; c.k = nk(op) ? k : 32'd0; c.v = nv(op) ? v : 32'd0; c.h = nk(op) ? h : 16'd0;
    if (legal(op)) expq.push_back(c);
    drive();
  endtask

  task automatic gen_random();
    logic [2:0] op;
    cmd_t c;
    op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    c.op = op;
    c.k = nk(op) ? $urandom : 32'd0;
    c.v = nv(op) ? $urandom : 32'd0;
    c.h = nk(op) ? 16'($urandom) : 16'd0;
    opp.push_back(op);
    if (nk(op)) begin kp.push_back(c.k); hp.push_back(c.h); end
    if (nv(op)) vp.push_back(c.v);
    if (legal(op)) expq.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (p_op && opq.size()) void'(opq.pop_front());
    if (p_k && kq.size()) void'(kq.pop_front());
    if (p_v && vq.size()) void'(vq.pop_front());
    if (p_h && hq.size()) void'(hq.pop_front());
    p_op = 0; p_k = 0; p_v = 0; p_h = 0;
    if (rnd) begin
      if (gen && opp.size() < 6 && $urandom_range(0, 99) < 50) gen_random();
      if (opp.size() && $urandom_range(0, 99) < dprob) opq.push_back(opp.pop_front());
      if (kp.size() && $urandom_range(0, 99) < dprob) kq.push_back(kp.pop_front());
      if (vp.size() && $urandom_range(0, 99) < dprob) vq.push_back(vp.pop_front());
      if (hp.size() && $urandom_range(0, 99) < dprob) hq.push_back(hp.pop_front());
    end
    drive();
  endtask

  // Queue owner clears its queues together with the issue stage.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    opq.delete(); kq.delete(); vq.delete(); hq.delete();
    opp.delete(); kp.delete(); vp.delete(); hp.delete();
    p_op = 0; p_k = 0; p_v = 0; p_h = 0;
    drive();
    @(posedge clk); #1;
    rst = 0; p_op = 0; p_k = 0; p_v = 0; p_h = 0;
    drive();
  endtask

  task automatic cnt_clear();
    cnt_credit = 0; cnt_vld = 0; cnt_vpop = 0;
  endtask

  // Cycle-level model: a command is held iff one was popped and not yet handshaken;
  // the head is taken whenever nothing is held, or the held one leaves and the head
  // is legal with its fields present.
  logic [2:0] m_op;
  bit         m_vld, m_hs, m_avail, m_pop, m_lg;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_pops", {o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'd0);
        chk("rst_credit_err", {o_credit, o_err_illegal}, 64'd0);
        expq.delete();
        outstanding = 0;
        p_op = 0; p_k = 0; p_v = 0; p_h = 0;
      end else begin
        m_op    = i_op_dat;
        m_lg    = legal(m_op);
        m_vld   = (outstanding > 0);
        m_hs    = m_vld && i_cmd_rdy;
        m_avail = (!nk(m_op) || !i_k_empty) && (!nv(m_op) || !i_v_empty) && (!nk(m_op) || !i_h_empty);
        if (i_op_empty) m_pop = 0;
        else if (m_vld) m_pop = m_hs && m_lg && m_avail;
        else            m_pop = !m_lg || m_avail;
        chk("op_pop", o_op_pop, m_pop);
        chk("k_pop", o_k_pop, m_pop && m_lg && nk(m_op));
        chk("v_pop", o_v_pop, m_pop && m_lg && nv(m_op));
        chk("h_pop", o_h_pop, m_pop && m_lg && nk(m_op));
        chk("err", o_err_illegal, m_pop && !m_lg);
        chk("credit", o_credit, m_hs || (m_pop && !m_lg));
        chk("vld", o_cmd_vld, m_vld);
        if (m_vld) begin
          if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_stream: got command with nothing expected (t=%0t)", $time);
          end else begin
            chk("cmd_op", o_cmd_opcode, expq[0].op);
            chk("cmd_k", o_cmd_k, expq[0].k);
            chk("cmd_v", o_cmd_v, expq[0].v);
            chk("cmd_h", o_cmd_h, expq[0].h);
          end
        end
        if (m_hs) begin
          if (expq.size()) void'(expq.pop_front());
          outstanding--;
        end
        if (o_op_pop && !i_op_empty && m_lg) outstanding++;
        cnt_credit += int'(o_credit);
        cnt_vld    += int'(o_cmd_vld);
        cnt_vpop   += int'(o_v_pop);
        p_op = o_op_pop; p_k = o_k_pop; p_v = o_v_pop; p_h = o_h_pop;
      end
    end
  end

  initial begin
    i_cmd_rdy = 0;
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    drive();
    @(negedge clk);
    chk("reset_cmd", {o_cmd_vld, o_cmd_opcode, o_cmd_h}, 64'd0);
    chk("reset_kv", {o_cmd_k, o_cmd_v}, 64'd0);
    chk("reset_misc", {o_credit, o_err_illegal, o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'd0);
    mon_en = 1;
    cyc();

    // single INSERT
    i_cmd_rdy = 1;
    push_cmd(3'd1, 32'hA5A5_0001, 32'h1234_5678, 16'h00FE, 1);
    @(negedge clk);
    chk("ins_pops", {o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'hF);
    cyc(); @(negedge clk);
    chk("ins_vld", o_cmd_vld, 64'd1);
    chk("ins_op", o_cmd_opcode, 64'd1);
    chk("ins_k", o_cmd_k, 64'hA5A5_0001);
    chk("ins_v", o_cmd_v, 64'h1234_5678);
    chk("ins_h", o_cmd_h, 64'h00FE);
    chk("ins_credit", o_credit, 64'd1);
    cyc(); @(negedge clk);
    chk("ins_done", o_cmd_vld, 64'd0);
    cyc();

    // QUERY whose hash arrives five cycles late
    push_cmd(3'd3, 32'hC0DE_0003, 32'hFFFF_FFFF, 16'h0BEE, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stag_wait", {o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'd0);
      cyc();
    end
    hq.push_back(16'h0BEE); drive();
    @(negedge clk);
    chk("stag_fire", {o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'hD);
    cyc(); @(negedge clk);
    chk("stag_k", o_cmd_k, 64'hC0DE_0003);
    chk("stag_v", o_cmd_v, 64'd0);
    chk("stag_h", o_cmd_h, 64'h0BEE);
    cyc(); cyc();

    // two DELETEs under backpressure
    i_cmd_rdy = 0; cnt_clear();
    push_cmd(3'd2, 32'h0000_D001, 32'd0, 16'h0D01, 1);
    push_cmd(3'd2, 32'h0000_D002, 32'd0, 16'h0D02, 1);
    @(negedge clk); cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) i_cmd_rdy = 1;
      @(negedge clk);
      chk("bp_hold_k", o_cmd_k, 64'h0000_D001);
      chk("bp_hold_h", o_cmd_h, 64'h0D01);
      if (i == 3) chk("bp_next_pop", o_op_pop, 64'd1);
      cyc();
    end
    @(negedge clk);
    chk("bp_second_k", o_cmd_k, 64'h0000_D002);
    cyc(); @(negedge clk);
    chk("bp_drained", o_cmd_vld, 64'd0);
    chk("bp_credits", cnt_credit, 64'd2);
    cyc();

    // 8 INSERTs back to back
    cnt_clear();
    for (int i = 0; i < 8; i++)
      push_cmd(3'd1, 32'h100 + i, 32'h200 + i, 16'(16'h300 + i), 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); cyc();
    end
    @(negedge clk);
    chk("thr_vld_cycles", cnt_vld, 64'd8);
    chk("thr_v_pops", cnt_vpop, 64'd8);
    chk("thr_done", o_cmd_vld, 64'd0);
    cyc();

    // illegal opcode, then NOP, then a QUERY whose fields sit ready throughout
    cnt_clear();
    push_cmd(3'd6, 32'd0, 32'd0, 16'd0, 1);
    push_cmd(3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'hBEEF, 1);
    push_cmd(3'd3, 32'h0000_0333, 32'd0, 16'h0333, 1);
    @(negedge clk);
    chk("ill_err", o_err_illegal, 64'd1);
    chk("ill_credit", o_credit, 64'd1);
    chk("ill_pops", {o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'h8);
    cyc(); @(negedge clk);
    chk("nop_pop", {o_err_illegal, o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'h8);
    cyc(); @(negedge clk);
    chk("nop_vld", o_cmd_vld, 64'd1);
    chk("nop_fields", {o_cmd_opcode, o_cmd_h, o_cmd_k[15:0]}, 64'd0);
    chk("nop_kv", {o_cmd_k, o_cmd_v}, 64'd0);
    cyc(); cyc(); cyc();

    // reset while holding an unaccepted command
    i_cmd_rdy = 0; cnt_clear();
    push_cmd(3'd1, 32'h7777_0001, 32'h7777_0002, 16'h7777, 1);
    @(negedge clk); cyc();
    @(negedge clk);
    chk("rstmid_held", o_cmd_vld, 64'd1);
    do_reset();
    @(negedge clk);
    chk("rstmid_cmd", {o_cmd_vld, o_cmd_opcode, o_cmd_h}, 64'd0);
    chk("rstmid_kv", {o_cmd_k, o_cmd_v}, 64'd0);
    chk("rstmid_misc", {o_credit, o_err_illegal, o_op_pop, o_k_pop, o_v_pop, o_h_pop}, 64'd0);
    chk("rstmid_no_credit", cnt_credit, 64'd0);
    cyc();

    // randomized traffic with occasional resets
    rnd = 1; gen = 1; dprob = 60;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      else cyc();
      i_cmd_rdy = ($urandom_range(0, 99) < 65);
    end
    gen = 0; dprob = 100; i_cmd_rdy = 1;
    repeat (80) cyc();
    @(negedge clk);
    chk("drain_expected", expq.size(), 64'd0);
    chk("drain_queues", opq.size() + kq.size() + vq.size() + hq.size(), 64'd0);
    chk("drain_pending", opp.size() + kp.size() + vp.size() + hp.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
